// File: rtl/mul_seq_arbiter.sv
// Round-robin arbiter and restart sequencer that shares one sequential array_mul
// between two valid/ready requesters and returns tagged products on one response port.
module mul_seq_arbiter #(
    parameter int N   = 4,
    parameter int LAT = N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_p,
    output logic           busy,
    output logic           mul_en,
    output logic [N-1:0]   mul_a,
    output logic [N-1:0]   mul_b,
    input  logic [2*N-1:0] mul_p
);

    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           prio_q, prio_d;
    logic           mul_en_q, mul_en_d;
    logic [N-1:0]   mul_a_q, mul_a_d;
    logic [N-1:0]   mul_b_q, mul_b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [2*N-1:0] rsp_p_q, rsp_p_d;
    logic           busy_q, busy_d;
    logic           grant;

    // Only a contested cycle consults the pointer; a lone requester always wins.
    assign grant = (req0_valid && req1_valid) ? prio_q : req1_valid;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_p_d     = rsp_p_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                req0_ready = req0_valid && !grant;
                req1_ready = req1_valid && grant;
                if (req0_ready || req1_ready) begin
                    mul_a_d  = grant ? req1_a : req0_a;
                    mul_b_d  = grant ? req1_b : req0_b;
                    rsp_id_d = grant;
                    prio_d   = !grant;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(LAT - 1)) begin
                    rsp_p_d     = mul_p;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The multiplier only sees en high in RUN, so LOAD always forces a restart.
        mul_en_d = (state_d == RUN);
        busy_d   = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prio_q      <= 1'b0;
            mul_en_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_p_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            mul_en_q    <= mul_en_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_p_q     <= rsp_p_d;
            busy_q      <= busy_d;
        end
    end

    assign mul_en    = mul_en_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul_seq_arbiter.sv
// Bench for mul_seq_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction model that predicts outputs from the age of the operation in flight.
module tb_mul_seq_arbiter;

    localparam int N   = 4;
    localparam int LAT = 4;
    localparam int PW  = 2 * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid, rsp_ready;
    logic [N-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          req0_ready, req1_ready, rsp_valid, rsp_id, busy, mul_en;
    logic [PW-1:0] rsp_p, mul_p;
    logic [N-1:0]  mul_a, mul_b;

    always #5 clk = ~clk;

    mul_seq_arbiter #(.N(N), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_p      (rsp_p),
        .busy       (busy),
        .mul_en     (mul_en),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p)
    );

    // Multiplier stand-in: product appears only after LAT-1 edges of continuous en,
    // otherwise a wrong value so an early or stale capture is visible.
    int mcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mcnt <= 0;
        else if (!mul_en) mcnt <= 0;
        else              mcnt <= mcnt + 1;
    end
    assign mul_p = (mul_en && mcnt >= LAT - 1) ? PW'(mul_a) * PW'(mul_b)
                                               : ~(PW'(mul_a) * PW'(mul_b));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Transaction model: one operation in flight, described by its age in cycles since accept.
    bit           m_busy;
    int           m_age;
    bit           m_prio;
    bit           m_id;
    logic [N-1:0] m_a, m_b;
    bit           hs0, hs1;

    typedef struct { bit id; logic [PW-1:0] p; } rsp_t;
    rsp_t dut_log[$];

    function automatic bit m_grant();
        if (req0_valid && req1_valid) return m_prio;
        return req1_valid;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_prio = 0; m_id = 0; m_a = '0; m_b = '0;
        hs0 = 0; hs1 = 0;
    endtask

    task automatic check_outputs();
        bit g;
        logic [PW-1:0] ep;
        g  = m_grant();
        ep = PW'(m_a) * PW'(m_b);
        check("req0_ready", 32'(req0_ready), 32'(!m_busy && req0_valid && !g));
        check("req1_ready", 32'(req1_ready), 32'(!m_busy && req1_valid && g));
        check("busy",       32'(busy),       32'(m_busy));
        check("mul_en",     32'(mul_en),     32'(m_busy && m_age >= 1 && m_age <= LAT));
        check("rsp_valid",  32'(rsp_valid),  32'(m_busy && m_age > LAT));
        if (m_busy) begin
            check("mul_a", 32'(mul_a), 32'(m_a));
            check("mul_b", 32'(mul_b), 32'(m_b));
        end
        if (m_busy && m_age > LAT) begin
            check("rsp_p",  32'(rsp_p),  32'(ep));
            check("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        if (rsp_valid && rsp_ready) dut_log.push_back('{rsp_id, rsp_p});
    endtask

    task automatic model_update();
        bit g;
        hs0 = 0; hs1 = 0;
        if (m_busy) begin
            if (m_age > LAT && rsp_ready) m_busy = 0;
            else m_age++;
        end else begin
            g = m_grant();
            if ((req0_valid && !g) || (req1_valid && g)) begin
                hs0    = !g;
                hs1    = g;
                m_a    = g ? req1_a : req0_a;
                m_b    = g ? req1_b : req0_b;
                m_id   = g;
                m_prio = !g;
                m_busy = 1;
                m_age  = 0;
            end
        end
    endtask

    // One clock: inputs set by caller just after the previous edge, outputs checked mid-cycle.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int max);
        int k = 0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        while (m_busy && k < max) begin
            cycle();
            k++;
        end
        check("drain_busy", 32'(busy), 32'(0));
    endtask

    task automatic expect_rsp(input string tag, input int idx, input bit id, input int p);
        if (dut_log.size() > idx) begin
            check({tag, "_id"}, 32'(dut_log[idx].id), 32'(id));
            check({tag, "_p"},  32'(dut_log[idx].p),  32'(p));
        end else begin
            check({tag, "_count"}, 32'(dut_log.size()), 32'(idx + 1));
        end
    endtask

    task automatic contend();
        req0_valid = 1; req0_a = 3; req0_b = 2;
        req1_valid = 1; req1_a = 2; req1_b = 2;
        rsp_ready  = 1;
        for (int k = 0; k < 40 && (req0_valid || req1_valid || m_busy); k++) begin
            cycle();
            if (hs0) req0_valid = 0;
            if (hs1) req1_valid = 0;
        end
        check("contend_done", 32'(busy), 32'(0));
    endtask

    initial begin
        rst_n = 0; rsp_ready = 0;
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        do_reset();

        // Reset values
        check("rst_rsp_p",  32'(rsp_p),  32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
        check("rst_mul_a",  32'(mul_a),  32'(0));
        check("rst_mul_b",  32'(mul_b),  32'(0));
        cycle();

        // Single request req0 10x5
        dut_log.delete();
        rsp_ready = 1; req0_valid = 1; req0_a = 10; req0_b = 5;
        cycle();
        req0_valid = 0;
        drain(20);
        check("single_count", 32'(dut_log.size()), 32'(1));
        expect_rsp("single", 0, 0, 50);

        // Max operands on req1
        dut_log.delete();
        req1_valid = 1; req1_a = 15; req1_b = 14;
        cycle();
        req1_valid = 0;
        drain(20);
        expect_rsp("max", 0, 1, 210);

        // Contention from reset, then again with pointer back at 0
        do_reset();
        dut_log.delete();
        contend();
        check("rr_count", 32'(dut_log.size()), 32'(2));
        expect_rsp("rr_first", 0, 0, 6);
        expect_rsp("rr_second", 1, 1, 4);
        dut_log.delete();
        contend();
        expect_rsp("rr_repeat", 0, 0, 6);

        // Backpressure in DONE with req1 waiting
        dut_log.delete();
        rsp_ready = 0; req0_valid = 1; req0_a = 6; req0_b = 7;
        cycle();
        req0_valid = 0;
        for (int k = 0; k < 20 && !(m_busy && m_age > LAT); k++) cycle();
        req1_valid = 1; req1_a = 5; req1_b = 3;
        repeat (6) cycle();
        rsp_ready = 1;
        cycle();
        cycle();
        check("bp_accept_next", 32'(hs1), 32'(1));
        req1_valid = 0;
        drain(20);
        expect_rsp("bp_first", 0, 0, 42);
        expect_rsp("bp_second", 1, 1, 15);

        // Reset during the second RUN cycle
        req0_valid = 1; req0_a = 9; req0_b = 9;
        cycle();
        req0_valid = 0;
        cycle();
        cycle();
        rst_n = 0;
        #1;
        check("rst_run_mul_en",    32'(mul_en),    32'(0));
        check("rst_run_busy",      32'(busy),      32'(0));
        check("rst_run_rsp_valid", 32'(rsp_valid), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        dut_log.delete();
        req0_valid = 1; req0_a = 2; req0_b = 2;
        cycle();
        req0_valid = 0;
        drain(20);
        repeat (3) cycle();
        check("post_rst_count", 32'(dut_log.size()), 32'(1));
        expect_rsp("post_rst", 0, 0, 4);

        // Operand change after accept
        dut_log.delete();
        req0_valid = 1; req0_a = 7; req0_b = 9;
        cycle();
        req0_valid = 0; req0_a = 1; req0_b = 1;
        drain(20);
        expect_rsp("opchg", 0, 0, 63);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = N'($urandom); req0_b = N'($urandom);
            req1_a = N'($urandom); req1_b = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
